crop_border: RTL and testbench

Strips the padded border from a padded pixel stream, recovering the original WIDTH-pixel lines after window operations (Sobel, NMS, hysteresis) in the Canny pipeline. Consumes lines of WIDTH+2N pixels qualified by a pixel strobe and separated by arbitrary gap cycles. Emits only the central WIDTH pixels per line, with line and frame markers. Optionally also drops the N padded rows at the top and bottom of the frame.

---
 rtl/crop_pkg.sv | 24 ++
 rtl/crop_border_if.sv | 23 ++
 rtl/crop_border_wrap_cnt.sv | 33 +++
 rtl/crop_border.sv | 117 +++++++++++
 tb/tb_crop_border.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/crop_pkg.sv
// Shared types and sizing helpers for the border cropper.
// Row cropping is compiled in with CROP_ROW_EN.
package crop_pkg;

  typedef enum logic [1:0] {IDLE, GAP, LINE} state_e;

  function automatic int line_len(input int w, input int n);
    return w + 2 * n;
  endfunction

  function automatic int rows(input int d, input int n);
`ifdef CROP_ROW_EN
    return d + 2 * n;
`else
    return d;
`endif
  endfunction

  // Counter width for a 0..m-1 counter; never collapses to zero bits.
  function automatic int cnt_w(input int m);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/crop_border_if.sv
// Pixel stream bundle: padded input side and cropped output side.
interface crop_border_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] fmap_pad;
  logic [DATA_WIDTH-1:0] fmap_crop;
  logic                  out_valid;
  logic                  line_end;
  logic                  frame_done;
  logic                  err_short;

  modport master (
    output start, in_valid, fmap_pad,
    input  fmap_crop, out_valid, line_end, frame_done, err_short
  );

  modport slave (
    input  start, in_valid, fmap_pad,
    output fmap_crop, out_valid, line_end, frame_done, err_short
  );
endinterface

// File: rtl/crop_border_wrap_cnt.sv
// Wrapping counter 0..MAX-1 with sync clear (priority over increment).
module wrap_cnt
  import crop_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_o  = cnt_q;
  assign wrap_o = inc_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (wrap_o) cnt_d = '0;
    else if (inc_i)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/crop_border.sv
// Strips N padded columns per side (and N padded rows when CROP_ROW_EN
// is defined) from a strobed pixel stream; all outputs registered.
module crop_border
  import crop_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int WIDTH      = 634,
  parameter int DEPTH      = 506,
  parameter int N          = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  crop_border_if.slave    bus
);
  localparam int LL  = line_len(WIDTH, N);
  localparam int RW  = rows(DEPTH, N);
  localparam int CW  = cnt_w(LL);
  localparam int RWW = cnt_w(RW);

  localparam logic [CW-1:0]  COL_LO = CW'(N);
  localparam logic [CW-1:0]  COL_HI = CW'(N + WIDTH - 1);
`ifdef CROP_ROW_EN
  localparam logic [RWW-1:0] ROW_LO = RWW'(N);
  localparam logic [RWW-1:0] ROW_HI = RWW'(N + DEPTH - 1);
`else
  localparam logic [RWW-1:0] ROW_HI = RWW'(DEPTH - 1);
`endif

  state_e                state_q, state_d;
  logic [CW-1:0]         col_cnt;
  logic [RWW-1:0]        row_cnt;
  logic                  col_wrap, row_wrap;
  logic                  accept, col_keep, row_keep, keep, last_col;
  logic                  err_d, vld_d, le_d, fd_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  err_q, vld_q, le_q, fd_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign accept = bus.start && bus.in_valid;

  wrap_cnt #(.MAX(LL), .W(CW)) u_col (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (!bus.start || err_d),
    .inc_i  (accept),
    .cnt_o  (col_cnt),
    .wrap_o (col_wrap)
  );

  wrap_cnt #(.MAX(RW), .W(RWW)) u_row (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (!bus.start),
    .inc_i  (col_wrap),
    .cnt_o  (row_cnt),
    .wrap_o (row_wrap)
  );

  // Keep decode on the pre-increment count of the pixel being accepted.
  assign col_keep = (col_cnt >= COL_LO) && (col_cnt <= COL_HI);
  assign last_col = (col_cnt == COL_HI);
`ifdef CROP_ROW_EN
  assign row_keep = (row_cnt >= ROW_LO) && (row_cnt <= ROW_HI);
`else
  assign row_keep = 1'b1;
`endif
  assign keep = accept && col_keep && row_keep;

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    vld_d   = keep;
    data_d  = keep ? bus.fmap_pad : '0;
    le_d    = keep && last_col;
    fd_d    = keep && last_col && (row_cnt == ROW_HI);
    unique case (state_q)
      IDLE: if (bus.start) state_d = accept ? LINE : GAP;
      GAP:  if (accept) state_d = LINE;
      LINE: begin
        if (accept && col_wrap) state_d = GAP;
        else if (!bus.in_valid) begin
          state_d = GAP;
          err_d   = bus.start;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!bus.start) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      le_q    <= 1'b0;
      fd_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      le_q    <= le_d;
      fd_q    <= fd_d;
      data_q  <= data_d;
    end
  end

  assign bus.fmap_crop  = data_q;
  assign bus.out_valid  = vld_q;
  assign bus.line_end   = le_q;
  assign bus.frame_done = fd_q;
  assign bus.err_short  = err_q;

  logic unused_ok;
  assign unused_ok = row_wrap;
endmodule

// File: tb/tb_crop_border.sv
// Randomized bench for crop_border against a counting reference model.
module tb_crop_border;
  localparam int DW    = 16;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int N     = 3;
  localparam int LL    = W + 2 * N;
`ifdef CROP_ROW_EN
  localparam int TOP   = N;
  localparam int ROWS  = DEPTH + 2 * N;
`else
  localparam int TOP   = 0;
  localparam int ROWS  = DEPTH;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  crop_border_if #(.DATA_WIDTH(DW)) bus ();

  crop_border #(.DATA_WIDTH(DW), .WIDTH(W), .DEPTH(DEPTH), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0, n_pass = 0;
  int n_out, n_le, n_fd, n_err;
  int m_col = 0, m_row = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Reference: plain column/row position of the next accepted pixel.
  task automatic tick();
    logic [DW+3:0] e, g;
    bit kept, le;
    e = '0;
    @(posedge clk);
    if (!rst_n || !bus.start) begin
      m_col = 0;
      m_row = 0;
    end else if (bus.in_valid) begin
      kept = m_col >= N && m_col < N + W && m_row >= TOP && m_row < TOP + DEPTH;
      le   = kept && m_col == N + W - 1;
      if (kept) e = {1'b0, le && m_row == TOP + DEPTH - 1, le, 1'b1, bus.fmap_pad};
      m_col++;
      if (m_col == LL) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
      end
    end else begin
      e[DW+3] = (m_col != 0);
      m_col = 0;
    end
    #1;
    g = {bus.err_short, bus.frame_done, bus.line_end, bus.out_valid, bus.fmap_crop};
    n_out += int'(bus.out_valid);
    n_le  += int'(bus.line_end);
    n_fd  += int'(bus.frame_done);
    n_err += int'(bus.err_short);
    chk("cyc", 32'(g), 32'(e));
  endtask

  task automatic clr_cnt();
    n_out = 0; n_le = 0; n_fd = 0; n_err = 0;
  endtask

  task automatic px(input logic [DW-1:0] d);
    bus.in_valid = 1'b1;
    bus.fmap_pad = d;
    tick();
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.fmap_pad = DW'($urandom);
    repeat (n) tick();
  endtask

  task automatic line(input int npix, input bit rnd);
    for (int c = 0; c < npix; c++) px(rnd ? DW'($urandom) : DW'(c));
  endtask

  task automatic restart();
    bus.start = 1'b0;
    idle(2);
    bus.start = 1'b1;
    idle(1);
  endtask

  task automatic skip_top();
    for (int r = 0; r < TOP; r++) begin
      line(LL, 1'b1);
      idle(1);
    end
  endtask

  initial begin
    bus.start = 1'b1; bus.in_valid = 1'b1; bus.fmap_pad = '0;
    clr_cnt();
    // reset held with start/in_valid high
    rst_n = 1'b0;
    px(DW'($urandom));
    px(DW'($urandom));
    chk("rst_out", 32'(n_out + n_err), 0);
    rst_n = 1'b1;
    clr_cnt();
    line(LL, 1'b0);
    idle(2);
    chk("first_out", 32'(n_out), (TOP == 0) ? 8 : 0);
    chk("first_le",  32'(n_le),  (TOP == 0) ? 1 : 0);

    // short line then full lines to the end of frame
    restart(); skip_top(); clr_cnt();
    line(6, 1'b0);
    idle(3);
    chk("short_out", 32'(n_out), 3);
    chk("short_err", 32'(n_err), 1);
    clr_cnt();
    line(LL, 1'b0);
    idle(2);
    chk("after_out", 32'(n_out), 8);
    chk("after_le",  32'(n_le), 1);
    clr_cnt();
    for (int r = 0; r < DEPTH - 1; r++) begin
      line(LL, 1'b1);
      idle($urandom_range(0, 3));
    end
    idle(2);
    chk("short_fd", 32'(n_fd), 1);

    // full frame with random gaps
    restart(); clr_cnt();
    for (int r = 0; r < ROWS; r++) begin
      line(LL, 1'b1);
      idle($urandom_range(1, 4));
    end
    chk("frame_out", 32'(n_out), 32);
    chk("frame_le",  32'(n_le), DEPTH);
    chk("frame_fd",  32'(n_fd), 1);
    chk("frame_err", 32'(n_err), 0);

    // abort mid-line with start low
    restart(); skip_top(); clr_cnt();
    line(8, 1'b0);
    bus.start = 1'b0;
    idle(3);
    chk("abort_out", 32'(n_out), 5);
    chk("abort_err", 32'(n_err), 0);
    bus.start = 1'b1;
    idle(1);
    clr_cnt();
    line(LL, 1'b0);
    idle(2);
    chk("resume_out", 32'(n_out), 8);
    chk("resume_le",  32'(n_le), 1);

    // back-to-back lines
    restart(); skip_top(); clr_cnt();
    repeat (3) line(LL, 1'b1);
    idle(2);
    chk("b2b_out", 32'(n_out), 24);
    chk("b2b_le",  32'(n_le), 3);

    // random soak including mid-frame resets and aborts
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      bus.start    = ($urandom_range(0, 99) != 0);
      bus.in_valid = ($urandom_range(0, 7) != 0);
      bus.fmap_pad = DW'($urandom);
      tick();
    end
    rst_n = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
